// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, a runtime baud divisor and sticky overflow.
// Latency: a write into an empty FIFO while idle drives the start bit one clock later.
// Backpressure: none; a write while full is dropped and sets overflow.
// Ports: clk/rst_n (async active-low); wr_en/wr_data push; baud_div clocks per bit,
//   sampled at frame start; ovf_clr clears overflow; fifo_full/fifo_empty/fifo_level
//   status; overflow sticky drop flag; tx_busy frame in progress; uart_tx serial out.
// Optional: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          ovf_clr,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------- FIFO ----------------
  logic [AW:0]           wptr_q, rptr_q;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic                  push, pop;
  logic [DATA_BITS-1:0]  head;
  logic                  ovf_q;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign fifo_level = wptr_q - rptr_q;
  assign push       = wr_en && !fifo_full;
  assign head       = mem_q[rptr_q[AW-1:0]];
  assign overflow   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (wr_en && fifo_full) ovf_q <= 1'b1;
      else if (ovf_clr)       ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

  // ---------------- Transmit FSM ----------------
  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d, busy_q;
  logic                  bit_end, last_data, last_stop, start_frame;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign div_eff   = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
  assign bit_end   = (cnt_q == '0);
  assign last_data = (bit_q == BW'(DATA_BITS-1));
  assign last_stop = (bit_q == BW'(STOP_BITS-1));
  // A frame starts from IDLE, or straight out of the last stop bit when more data waits.
  assign start_frame = !fifo_empty &&
                       ((state_q == IDLE) || (state_q == STOP && bit_end && last_stop));
  assign tx_busy   = busy_q;
  assign uart_tx   = tx_q;

  // State register (with datapath registers).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(1);
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (bit_end) state_d = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && last_data) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:  if (bit_end && last_data) state_d = STOP;
`endif
      STOP:  if (bit_end && last_stop) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic; tx_d is registered so uart_tx is glitch-free.
  always_comb begin
    pop     = 1'b0;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (start_frame) begin
      pop     = 1'b1;
      shift_d = head;
      div_d   = div_eff;
      cnt_d   = div_eff - DIV_WIDTH'(1);
      bit_d   = '0;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ (PARITY_ODD != 0);
`endif
    end else if (state_q != IDLE) begin
      if (!bit_end) begin
        cnt_d = cnt_q - DIV_WIDTH'(1);
      end else begin
        cnt_d = div_q - DIV_WIDTH'(1);
        unique case (state_q)
          START: begin
            tx_d  = shift_q[0];
            bit_d = '0;
          end
          DATA: begin
            if (last_data) begin
`ifdef UART_TX_PARITY_EN
              tx_d = par_q;
`else
              tx_d = 1'b1;
`endif
              bit_d = '0;
            end else begin
              shift_d = shift_q >> 1;
              tx_d    = shift_q[1];
              bit_d   = bit_q + BW'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            tx_d  = 1'b1;
            bit_d = '0;
          end
`endif
          STOP: begin
            tx_d = 1'b1;
            if (!last_stop) bit_d = bit_q + BW'(1);
          end
          default: tx_d = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int SLOTS = 10 + P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [15:0] baud_div = 16'd4;
  logic        ovf_clr = 1'b0;
  logic        fifo_full, fifo_empty, overflow, tx_busy, uart_tx;
  logic [4:0]  fifo_level;

  int errs = 0;
  int checks = 0;
  logic [127:0] wave;
  int sidx;
  int busy_n;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .baud_div(baud_div), .ovf_clr(ovf_clr), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .overflow(overflow),
    .tx_busy(tx_busy), .uart_tx(uart_tx)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line waveform of one frame, one bit per clock, earliest clock in bit 0.
  function automatic logic [127:0] exp_frame(input logic [7:0] d, input int div);
    logic [127:0] v;
    int s;
    v = '0;
    for (int t = 0; t < SLOTS * div; t++) begin
      s = t / div;
      if (s == 0)                 v[t] = 1'b0;
      else if (s <= 8)            v[t] = d[s-1];
      else if (P == 1 && s == 9)  v[t] = ^d;
      else                        v[t] = 1'b1;
    end
    return v;
  endfunction

  task automatic clr_wave();
    wave = '0;
    sidx = 0;
    busy_n = 0;
  endtask

  task automatic samp();
    wave[sidx] = uart_tx;
    busy_n += int'(tx_busy);
    sidx++;
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      @(negedge clk);
      samp();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset and idle
    do_reset();
    repeat (20) @(negedge clk);
    chk("t1_uart_tx", uart_tx, 1);
    chk("t1_empty", fifo_empty, 1);
    chk("t1_full", fifo_full, 0);
    chk("t1_level", fifo_level, 0);
    chk("t1_busy", tx_busy, 0);
    chk("t1_ovf", overflow, 0);

    // 2: single 0xA5 at baud_div=4
    baud_div = 16'd4; wr_data = 8'hA5; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t2_tx_at_n", uart_tx, 1);
    chk("t2_level_at_n", fifo_level, 1);
    clr_wave();
    capture(SLOTS * 4);
    chk("t2_wave", wave, exp_frame(8'hA5, 4));
    chk("t2_busy_clocks", busy_n, SLOTS * 4);
    @(negedge clk);
    chk("t2_busy_after", tx_busy, 0);
    chk("t2_tx_after", uart_tx, 1);
    chk("t2_empty_after", fifo_empty, 1);

    // 3: three back-to-back frames at baud_div=2
    baud_div = 16'd2; wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_data = 8'h00;
    clr_wave();
    @(negedge clk);
    samp();
    wr_data = 8'hFF;
    @(negedge clk);
    samp();
    wr_en = 1'b0;
    capture(3 * SLOTS * 2 - 2);
    chk("t3_wave", wave, exp_frame(8'h55, 2) | (exp_frame(8'h00, 2) << (SLOTS * 2))
                         | (exp_frame(8'hFF, 2) << (2 * SLOTS * 2)));
    chk("t3_busy_clocks", busy_n, 3 * SLOTS * 2);
    @(negedge clk);
    chk("t3_busy_after", tx_busy, 0);

    // 4: fill to full at baud_div=100, overflow, clear
    baud_div = 16'd100; wr_en = 1'b1; wr_data = 8'd0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("t4_level_after_pop", fifo_level, 1);
        chk("t4_busy", tx_busy, 1);
      end
      if (k == 17) begin
        chk("t4_level16", fifo_level, 16);
        chk("t4_full", fifo_full, 1);
        chk("t4_ovf_before_drop", overflow, 0);
      end
      wr_data = 8'(k);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("t4_ovf_set", overflow, 1);
    chk("t4_level_after_drop", fifo_level, 16);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t4_ovf_cleared", overflow, 0);
    wr_en = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("t4_set_wins", overflow, 1);
    do_reset();
    chk("t4_reset_empty", fifo_empty, 1);
    chk("t4_reset_level", fifo_level, 0);
    chk("t4_reset_ovf", overflow, 0);

    // 5: reset during data bit 3 of 0xA5 with 0x3C queued
    baud_div = 16'd4; wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (17) @(negedge clk);
    chk("t5_midframe_busy", tx_busy, 1);
    chk("t5_midframe_bit3", uart_tx, 0);
    chk("t5_midframe_level", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", uart_tx, 1);
    chk("t5_rst_empty", fifo_empty, 1);
    chk("t5_rst_busy", tx_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_wave();
    capture(40);
    chk("t5_line_idle", wave, 128'hFF_FFFF_FFFF);
    chk("t5_no_frame", busy_n, 0);

    // 6: baud_div=0 behaves as one clock per bit
    baud_div = 16'd0; wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    clr_wave();
    capture(SLOTS);
    chk("t6_div0_wave", wave, exp_frame(8'h3C, 1));
    chk("t6_div0_busy", busy_n, SLOTS);
    @(negedge clk);
    chk("t6_div0_idle", tx_busy, 0);

`ifdef UART_TX_PARITY_EN
    baud_div = 16'd3; wr_en = 1'b1; wr_data = 8'h07;
    @(negedge clk);
    wr_en = 1'b0;
    clr_wave();
    capture(33);
    chk("t6_par_wave", wave, exp_frame(8'h07, 3));
    chk("t6_par_bit", wave[27], 1);
    chk("t6_par_busy", busy_n, 33);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
